// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin packet arbiter feeding one FIFO write port.
// Grants are locked for a whole packet and tagged with the source id.
module fifo_wr_arbiter #(
  parameter int DSIZE = 8,
  parameter int NREQ = 4,
  parameter int IDW = 2
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  fifo_winc,
  output logic [IDW+DSIZE-1:0]  fifo_wdata,
  input  logic                  fifo_wfull,
  input  logic                  fifo_awfull,
  output logic                  busy,
  output logic [IDW-1:0]        grant_id,
  output logic [15:0]           pkt_cnt
);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state, state_nx;
  logic [IDW-1:0] grant_nx, winner, idx;
  logic [15:0] cnt_q;
  logic [DSIZE-1:0] cur_data;
  logic accept, done, found;
  assign busy = state == XFER;
  assign cur_data = req_data[grant_id*DSIZE +: DSIZE];
  assign accept = busy & req_valid[grant_id] & ~fifo_wfull;
  assign done = accept & req_last[grant_id];
  assign fifo_winc = accept;
  assign fifo_wdata = {grant_id, cur_data};
  assign req_ready = (busy && !fifo_wfull) ? NREQ'(1) << grant_id : '0;
  assign pkt_cnt = cnt_q;
  // search starts one past the last grant, wrapping at NREQ-1
  always_comb begin
    winner = grant_id;
    found = 1'b0;
    idx = grant_id;
    for (int k = 0; k < NREQ; k++) begin
      idx = (idx == IDW'(NREQ - 1)) ? '0 : idx + IDW'(1);
      if (!found && req_valid[idx]) begin
        winner = idx;
        found = 1'b1;
      end
    end
    state_nx = state;
    grant_nx = grant_id;
    if (state == IDLE) begin
      if (found && !fifo_awfull) begin
        state_nx = XFER;
        grant_nx = winner;
      end
    end else if (done) begin
      state_nx = IDLE;
    end
  end
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state <= IDLE;
      grant_id <= IDW'(NREQ - 1);
      cnt_q <= '0;
    end else begin
      state <= state_nx;
      grant_id <= grant_nx;
      if (done) cnt_q <= cnt_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: vector table plus queue-driven requesters and a FIFO-write scoreboard.
module tb_fifo_wr_arbiter;
  localparam int DSIZE = 8;
  localparam int NREQ = 4;
  localparam int IDW = 2;
  logic wclk = 1'b0;
  logic wrst_n = 1'b1;
  logic [NREQ-1:0] req_valid = '0, req_last = '0, req_ready;
  logic [NREQ*DSIZE-1:0] req_data = '0;
  logic fifo_winc, fifo_wfull = 1'b0, fifo_awfull = 1'b0, busy;
  logic [IDW+DSIZE-1:0] fifo_wdata;
  logic [IDW-1:0] grant_id;
  logic [15:0] pkt_cnt;
  int total = 0, bad = 0;
  logic [IDW+DSIZE-1:0] sb[$];
  logic [DSIZE:0] rq[NREQ][$];
  logic smp_winc, smp_busy;
  logic [NREQ-1:0] smp_ready;
  logic [IDW-1:0] smp_grant;
  logic [6:0] hist;
  typedef struct {
    logic [3:0] v, l;
    logic wf, af, eb;
    logic [1:0] eg;
    logic ew;
    logic [3:0] er;
    logic [15:0] ec;
  } vec_t;
  vec_t tbl[19];

  fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .IDW(IDW)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_winc(fifo_winc),
    .fifo_wdata(fifo_wdata), .fifo_wfull(fifo_wfull), .fifo_awfull(fifo_awfull),
    .busy(busy), .grant_id(grant_id), .pkt_cnt(pkt_cnt)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic mon();
    logic [IDW+DSIZE-1:0] e;
    if (fifo_winc) begin
      if (fifo_wfull) chk("winc_while_full", 1, 0);
      if (sb.size() == 0) chk("unexpected_winc", int'(fifo_wdata), -1);
      else begin
        e = sb.pop_front();
        chk("wdata", int'(fifo_wdata), int'(e));
      end
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    wrst_n = 1'b0;
    @(negedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  // Each cycle: present queue heads at negedge, sample mid-cycle, pop handshaked beats.
  task automatic run_q(input int n);
    logic [NREQ-1:0] hs;
    logic [DSIZE:0] d;
    repeat (n) begin
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = rq[i].size() > 0;
        d = (rq[i].size() > 0) ? rq[i][0] : '0;
        req_last[i] = d[DSIZE];
        req_data[i*DSIZE +: DSIZE] = d[DSIZE-1:0];
      end
      #4;
      mon();
      smp_winc = fifo_winc;
      smp_busy = busy;
      smp_ready = req_ready;
      smp_grant = grant_id;
      hs = req_ready & req_valid;
      @(negedge wclk);
      for (int i = 0; i < NREQ; i++) if (hs[i]) d = rq[i].pop_front();
    end
  endtask

  initial begin
    tbl[0]  = '{4'b0101, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 4'b0000, 16'd0};
    tbl[1]  = '{4'b0101, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 16'd0};
    tbl[2]  = '{4'b0101, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 16'd1};
    tbl[3]  = '{4'b0101, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100, 16'd1};
    tbl[4]  = '{4'b0101, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 4'b0000, 16'd2};
    tbl[5]  = '{4'b0101, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 16'd2};
    tbl[6]  = '{4'b0101, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 16'd3};
    tbl[7]  = '{4'b0101, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100, 16'd3};
    tbl[8]  = '{4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 4'b0000, 16'd4};
    tbl[9]  = '{4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 4'b0000, 16'd4};
    tbl[10] = '{4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 4'b0000, 16'd4};
    tbl[11] = '{4'b1111, 4'b1111, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1000, 16'd4};
    tbl[12] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 4'b0000, 16'd5};
    tbl[13] = '{4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 4'b0000, 16'd5};
    tbl[14] = '{4'b0010, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0000, 16'd5};
    tbl[15] = '{4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010, 16'd5};
    tbl[16] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0010, 16'd5};
    tbl[17] = '{4'b1111, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010, 16'd5};
    tbl[18] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 4'b0000, 16'd6};
    // reset held with every requester asserting
    req_valid = '1;
    req_last = '1;
    #1 wrst_n = 1'b0;
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_grant", int'(grant_id), NREQ - 1);
    chk("rst_cnt", int'(pkt_cnt), 0);
    chk("rst_winc", int'(fifo_winc), 0);
    chk("rst_ready", int'(req_ready), 0);
    @(negedge wclk);
    do_reset();
    // table: alternating single-beat grants, awfull, wfull, dropped valid
    req_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    for (int n = 0; n < 19; n++) begin
      req_valid = tbl[n].v;
      req_last = tbl[n].l;
      fifo_wfull = tbl[n].wf;
      fifo_awfull = tbl[n].af;
      if (tbl[n].ew) sb.push_back({tbl[n].eg, 8'hD0 + {6'd0, tbl[n].eg}});
      #4;
      chk($sformatf("v%0d_busy", n), int'(busy), int'(tbl[n].eb));
      chk($sformatf("v%0d_grant", n), int'(grant_id), int'(tbl[n].eg));
      chk($sformatf("v%0d_winc", n), int'(fifo_winc), int'(tbl[n].ew));
      chk($sformatf("v%0d_ready", n), int'(req_ready), int'(tbl[n].er));
      chk($sformatf("v%0d_cnt", n), int'(pkt_cnt), int'(tbl[n].ec));
      mon();
      @(negedge wclk);
    end
    fifo_wfull = 1'b0;
    fifo_awfull = 1'b0;
    // 3-beat packet from requester 1 while requester 3 waits
    do_reset();
    rq[1] = '{{1'b0, 8'hA1}, {1'b0, 8'hA2}, {1'b1, 8'hA3}};
    rq[3] = '{{1'b1, 8'h3C}};
    sb = '{{2'd1, 8'hA1}, {2'd1, 8'hA2}, {2'd1, 8'hA3}, {2'd3, 8'h3C}};
    for (int c = 0; c < 7; c++) begin
      run_q(1);
      hist[c] = smp_winc;
    end
    chk("burst_pattern", int'(hist), 7'b0101110);
    // wfull stall for 5 cycles mid-packet
    rq[2] = '{{1'b0, 8'h51}, {1'b0, 8'h52}, {1'b0, 8'h53}, {1'b1, 8'h54}};
    sb = '{{2'd2, 8'h51}, {2'd2, 8'h52}, {2'd2, 8'h53}, {2'd2, 8'h54}};
    run_q(2);
    fifo_wfull = 1'b1;
    repeat (5) begin
      run_q(1);
      chk("stall_winc", int'(smp_winc), 0);
      chk("stall_ready", int'(smp_ready), 0);
      chk("stall_grant", int'(smp_grant), 2);
      chk("stall_busy", int'(smp_busy), 1);
    end
    fifo_wfull = 1'b0;
    run_q(4);
    chk("stall_drained", rq[2].size(), 0);
    chk("stall_cnt", int'(pkt_cnt), 3);
    // almost-full blocks new grants but not an active packet
    rq[0] = '{{1'b1, 8'h60}};
    rq[1] = '{{1'b1, 8'h61}};
    rq[2] = '{{1'b1, 8'h62}};
    rq[3] = '{{1'b0, 8'h63}, {1'b1, 8'h64}};
    fifo_awfull = 1'b1;
    repeat (3) begin
      run_q(1);
      chk("awf_busy", int'(smp_busy), 0);
      chk("awf_grant", int'(smp_grant), 2);
    end
    fifo_awfull = 1'b0;
    run_q(1);
    fifo_awfull = 1'b1;
    sb = '{{2'd3, 8'h63}, {2'd3, 8'h64}};
    repeat (2) begin
      run_q(1);
      chk("awf_xfer_winc", int'(smp_winc), 1);
    end
    repeat (2) begin
      run_q(1);
      chk("awf_idle_busy", int'(smp_busy), 0);
    end
    chk("awf_cnt", int'(pkt_cnt), 4);
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    fifo_awfull = 1'b0;
    // async reset during beat 2 of a 4-beat packet
    rq[1] = '{{1'b0, 8'h71}, {1'b0, 8'h72}, {1'b0, 8'h73}, {1'b1, 8'h74}};
    sb = '{{2'd1, 8'h71}};
    run_q(2);
    req_valid = 4'b0010;
    req_last = 4'b0000;
    req_data[1*DSIZE +: DSIZE] = 8'h72;
    #2 wrst_n = 1'b0;
    #1;
    chk("mid_rst_winc", int'(fifo_winc), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ready", int'(req_ready), 0);
    chk("mid_rst_cnt", int'(pkt_cnt), 0);
    chk("mid_rst_grant", int'(grant_id), 3);
    @(negedge wclk);
    wrst_n = 1'b1;
    rq[1].delete();
    rq[0] = '{{1'b1, 8'h80}};
    rq[1] = '{{1'b1, 8'h81}};
    sb = '{{2'd0, 8'h80}, {2'd1, 8'h81}};
    run_q(2);
    chk("post_rst_grant", int'(smp_grant), 0);
    chk("post_rst_winc", int'(smp_winc), 1);
    run_q(2);
    chk("post_rst_cnt", int'(pkt_cnt), 2);
    // counter wrap
    req_valid = '0;
    force dut.cnt_q = 16'hFFFF;
    #1 release dut.cnt_q;
    #1 chk("wrap_pre", int'(pkt_cnt), 16'hFFFF);
    @(negedge wclk);
    rq[2] = '{{1'b1, 8'h90}};
    sb = '{{2'd2, 8'h90}};
    run_q(3);
    chk("wrap_cnt", int'(pkt_cnt), 0);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DSIZE, default 8, payload width per requester beat.
REQ-002 Parameter NREQ, default 4, number of requesters; legal range 2..8.
REQ-003 Parameter IDW, default 2, source-tag width; SHALL equal clog2(NREQ).
REQ-004 wclk  in  1  sole clock; all logic rising-edge.
REQ-005 wrst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  NREQ  per-requester beat valid.
REQ-007 req_last  in  NREQ  per-requester final beat of packet.
REQ-008 req_data  in  NREQ*DSIZE  per-requester payload, requester i at bits [i*DSIZE +: DSIZE].
REQ-009 req_ready  out  NREQ  per-requester beat accepted this cycle.
REQ-010 fifo_winc  out  1  write strobe to FIFO write port.
REQ-011 fifo_wdata  out  IDW+DSIZE  {source id, payload} to FIFO.
REQ-012 fifo_wfull  in  1  FIFO full, wclk domain.
REQ-013 fifo_awfull  in  1  FIFO almost-full, wclk domain.
REQ-014 busy  out  1  packet in progress (state XFER).
REQ-015 grant_id  out  IDW  current/last granted requester.
REQ-016 pkt_cnt  out  16  completed packets, wraps at 0xFFFF -> 0.

Function
REQ-017 FSM states: IDLE, XFER.
REQ-018 IDLE: when any req_valid set and fifo_awfull=0, select winner round-robin starting at (grant_id+1) mod NREQ, register grant_id, next state XFER.
REQ-019 IDLE with fifo_awfull=1: no grant, stay IDLE, grant_id unchanged.
REQ-020 IDLE: req_ready all 0, fifo_winc 0.
REQ-021 XFER: accept = req_valid[grant_id] & ~fifo_wfull; fifo_winc = accept; req_ready[grant_id] = ~fifo_wfull; other req_ready bits 0.
REQ-022 fifo_winc, req_ready combinational from state/grant_id/inputs; zero-cycle latency requester-to-FIFO.
REQ-023 fifo_wdata = {grant_id, req_data of grant_id}; value don't-care when fifo_winc=0.
REQ-024 XFER: grant locked until beat with req_last[grant_id]=1 accepted; then next state IDLE, pkt_cnt increments.
REQ-025 fifo_awfull ignored in XFER; only fifo_wfull stalls mid-packet.
REQ-026 fifo_wfull stall: no winc, grant held, data not consumed; resumes when fifo_wfull clears.
REQ-027 Requester drops req_valid mid-packet: grant held indefinitely, no winc.
REQ-028 Exactly one bubble cycle (IDLE) between consecutive packets.
REQ-029 Single-beat packet (valid and last first beat): one XFER cycle if not full.
REQ-030 Never fifo_winc while fifo_wfull=1.
REQ-031 req_valid changes on non-granted requesters in XFER have no effect.
REQ-032 Round-robin fairness: requester continuously valid granted within NREQ packets.

Reset
REQ-033 wrst_n low asynchronously forces: state IDLE, grant_id = NREQ-1 (so requester 0 first), pkt_cnt 0, busy 0; req_ready 0 and fifo_winc 0 while held.
REQ-034 Reset mid-packet aborts packet with no further winc; pkt_cnt not incremented.
REQ-035 Release synchronous to wclk is caller's responsibility; first grant no earlier than first rising edge after release.

Verification
REQ-036 After reset, req_valid=0b0101 all single-beat, FIFO empty -> grants 0,2,0,2; fifo_wdata tags 0,2; pkt_cnt 4 after 8 cycles.
REQ-037 Requester 1 sends 3-beat packet 0xA1,0xA2,0xA3 while requester 3 valid -> FIFO receives {1,A1},{1,A2},{1,A3} uninterrupted, then {3,..} after one bubble.
REQ-038 fifo_wfull=1 for 5 cycles mid-packet -> fifo_winc 0 and req_ready 0 for those cycles, grant unchanged, beat after release equals stalled beat.
REQ-039 fifo_awfull=1 in IDLE with req_valid=0b1111 -> no grant, busy 0 until awfull clears; awfull set in XFER -> packet completes.
REQ-040 wrst_n asserted during beat 2 of a 4-beat packet -> fifo_winc 0 immediately, state IDLE, pkt_cnt 0, next grant to requester 0.
REQ-041 Force pkt_cnt through 0xFFFF with one more packet -> pkt_cnt reads 0x0000.
